// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and the arbiter FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant generator. On a tie the requester that was not
// granted last wins; a lone request always wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between the fetch and execute requesters,
// one operation in flight, with registered operands and registered responses.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    input  logic             rsp_ready
);

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [1:0] grant;
    logic       handshake;

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    // The grant is a subset of req_valid, so ready is only offered to live requests.
    assign req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign handshake = |(req_valid & req_ready);

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d      = state_q;
        last_d       = last_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_valid_d  = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    alu_a_d    = grant[1] ? req1_a    : req0_a;
                    alu_b_d    = grant[1] ? req1_b    : req0_b;
                    alu_ctrl_d = grant[1] ? req1_ctrl : req0_ctrl;
                    id_d       = grant[1];
                    last_d     = grant[1];
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Operands are left untouched between grants so the ALU inputs stay quiet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= ALU_ADD;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            last_q       <= last_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a vector table of complete operations plus
// hand-written sequences for response back-pressure, reset mid-flight and single-requester streaming.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_ctrl, req1_ctrl;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_ready;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_ready  (rsp_ready)
    );

    // Stand-in for the external ALU that the parent places next to the arbiter.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLL: alu_result = alu_a << alu_b[4:0];
            ALU_SRL: alu_result = alu_a >> alu_b[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0;
        logic [2:0]  c0;
        logic [31:0] a1, b1;
        logic [2:0]  c1;
        logic [1:0]  grant;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge with the arbiter idle; returns at a falling edge, idle again.
    task automatic do_op(input string tag, input vec_t v);
        logic        gid;
        logic [31:0] ea, eb;
        logic [2:0]  ec;
        gid = v.grant[1];
        ea  = gid ? v.a1 : v.a0;
        eb  = gid ? v.b1 : v.b0;
        ec  = gid ? v.c1 : v.c0;
        req_valid = v.valid;
        req0_a = v.a0; req0_b = v.b0; req0_ctrl = v.c0;
        req1_a = v.a1; req1_b = v.b1; req1_ctrl = v.c1;
        rsp_ready = 1'b0;
        #1;
        check({tag, " grant"}, 32'(req_ready), 32'(v.grant));
        tick();
        check({tag, " exec ready"}, 32'(req_ready), 32'd0);
        check({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " alu_a"}, alu_a, ea);
        check({tag, " alu_b"}, alu_b, eb);
        check({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(ec));
        tick();
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(gid));
        check({tag, " rsp_result"}, rsp_result, v.res);
        check({tag, " rsp_zero"}, 32'(rsp_zero), 32'(v.zero));
        check({tag, " resp ready"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vec_t v;

        //          valid  a0            b0            c0       a1            b1            c1       grant  res           zero
        vecs[0] = '{2'b01, 32'd5,        32'd7,        ALU_ADD, 32'd0,        32'd0,        ALU_ADD, 2'b01, 32'd12,       1'b0};
        vecs[1] = '{2'b10, 32'd0,        32'd0,        ALU_ADD, 32'd9,        32'd9,        ALU_SUB, 2'b10, 32'd0,        1'b1};
        vecs[2] = '{2'b11, 32'h0000F0F0, 32'h00000FF0, ALU_AND, 32'd3,        32'd3,        ALU_OR,  2'b01, 32'h000000F0, 1'b0};
        vecs[3] = '{2'b11, 32'd7,        32'd7,        ALU_ADD, 32'd1,        32'd4,        ALU_SLL, 2'b10, 32'h00000010, 1'b0};
        vecs[4] = '{2'b11, 32'hFFFF0000, 32'h0F0F0F0F, ALU_XOR, 32'd2,        32'd2,        ALU_ADD, 2'b01, 32'hF0F00F0F, 1'b0};
        vecs[5] = '{2'b11, 32'd1,        32'd1,        ALU_ADD, 32'h80000000, 32'd31,       ALU_SRL, 2'b10, 32'h00000001, 1'b0};
        vecs[6] = '{2'b10, 32'd0,        32'd0,        ALU_ADD, 32'd3,        32'd5,        ALU_SLT, 2'b10, 32'h00000001, 1'b0};
        vecs[7] = '{2'b01, 32'd0,        32'd1,        ALU_SUB, 32'd0,        32'd0,        ALU_ADD, 2'b01, 32'hFFFFFFFF, 1'b0};
        vecs[8] = '{2'b11, 32'd0,        32'd0,        ALU_ADD, 32'hFFFFFFFF, 32'd1,        ALU_ADD, 2'b10, 32'd0,        1'b1};

        reset_n = 1'b0;
        req_valid = 2'b00;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        rsp_ready = 1'b0;
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        check("reset rsp_result", rsp_result, 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-pressure: response held for five cycles while both requesters wait.
        v = '{2'b11, 32'd100, 32'd23, ALU_ADD, 32'd1, 32'd1, ALU_SUB, 2'b01, 32'd123, 1'b0};
        req_valid = v.valid;
        req0_a = v.a0; req0_b = v.b0; req0_ctrl = v.c0;
        req1_a = v.a1; req1_b = v.b1; req1_ctrl = v.c1;
        #1;
        check("hold grant", 32'(req_ready), 32'(2'b01));
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("hold%0d rsp_result", k), rsp_result, 32'd123);
            check($sformatf("hold%0d rsp_id", k), 32'(rsp_id), 32'd0);
            check($sformatf("hold%0d req_ready", k), 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("hold release rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        rsp_ready = 1'b0;
        check("hold idle rsp_valid", 32'(rsp_valid), 32'd0);
        check("hold idle grant", 32'(req_ready), 32'(2'b10));
        req_valid = 2'b00;
        #1;
        check("withdraw req_ready", 32'(req_ready), 32'd0);
        tick();

        // Reset while the operation sits in EXEC.
        req_valid = 2'b01;
        req0_a = 32'd1; req0_b = 32'd4; req0_ctrl = ALU_SLL;
        #1;
        check("rst grant", 32'(req_ready), 32'(2'b01));
        tick();
        check("rst pre alu_a", alu_a, 32'd1);
        check("rst pre alu_ctrl", 32'(alu_ctrl), 32'(ALU_SLL));
        req_valid = 2'b00;
        reset_n = 1'b0;
        #1;
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_result", rsp_result, 32'd0);
        check("rst rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rst quiet%0d", k), 32'(rsp_valid), 32'd0);
        end
        req_valid = 2'b11;
        #1;
        check("rst first tie", 32'(req_ready), 32'(2'b01));
        req_valid = 2'b00;
        tick();

        // Requester 1 alone, three back-to-back operations.
        v = '{2'b10, 32'd0, 32'd0, ALU_ADD, 32'h0000F0F0, 32'h00000FF0, ALU_AND, 2'b10, 32'h000000F0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            do_op($sformatf("solo%0d", k), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
